// File: rtl/vtx_trace_capture_if.sv
// Observed coprocessor-issue, coprocessor-result and memory bus signals.
// The trace capture block only listens (slave modport: all inputs); the
// master modport is the side that actually drives the bus.
//
// Handshake rules: an issue fires when cop_insn_valid and cop_insn_ready
// are both high on a rising clock edge; a result fires when cop_rsp_valid
// and cop_rsp_ready are both high; a memory request is accepted when
// mem_req and mem_gnt are both high; mem_ack is a one-cycle response strobe
// carrying mem_rdata/mem_error, with no ready side.
interface vtx_trace_capture_if;
  logic        cop_insn_valid;
  logic        cop_insn_ready;
  logic [31:0] cop_insn_enc;
  logic [31:0] cop_insn_rs1;
  logic        cop_rsp_valid;
  logic        cop_rsp_ready;
  logic [2:0]  cop_rsp_result;
  logic [31:0] cop_rsp_wdata;
  logic [4:0]  cop_rsp_waddr;
  logic        cop_rsp_wen;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_ben;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_error;

  modport master (
    output cop_insn_valid, cop_insn_ready, cop_insn_enc, cop_insn_rs1,
    output cop_rsp_valid, cop_rsp_ready, cop_rsp_result, cop_rsp_wdata,
    output cop_rsp_waddr, cop_rsp_wen,
    output mem_req, mem_gnt, mem_wen, mem_addr, mem_wdata, mem_ben,
    output mem_ack, mem_rdata, mem_error
  );

  modport slave (
    input cop_insn_valid, cop_insn_ready, cop_insn_enc, cop_insn_rs1,
    input cop_rsp_valid, cop_rsp_ready, cop_rsp_result, cop_rsp_wdata,
    input cop_rsp_waddr, cop_rsp_wen,
    input mem_req, mem_gnt, mem_wen, mem_addr, mem_wdata, mem_ben,
    input mem_ack, mem_rdata, mem_error
  );
endinterface

// File: rtl/vtx_trace_capture.sv
// Passive trace capture of one coprocessor instruction at a time: issue
// fields, up to four memory transactions, result/writeback, and CPR file
// snapshots before and after. Emits a one-cycle vtx_valid on retirement.
// Optional feature: define VTX_RAND_SAMPLE_EN to latch rand_in at issue;
// otherwise vtx_rand_sample is tied to zero.
module vtx_trace_capture (
  input  logic                 vtx_clk,
  input  logic                 vtx_reset,
  vtx_trace_capture_if.slave   bus,
  input  logic [511:0]         cprs_in,
  input  logic [31:0]          rand_in,
  output logic                 vtx_valid,
  output logic [31:0]          vtx_instr_enc,
  output logic [31:0]          vtx_instr_rs1,
  output logic [2:0]           vtx_instr_result,
  output logic [31:0]          vtx_instr_wdata,
  output logic [4:0]           vtx_instr_waddr,
  output logic                 vtx_instr_wen,
  output logic [3:0]           vtx_mem_cen,
  output logic [3:0]           vtx_mem_wen,
  output logic [3:0]           vtx_mem_error,
  output logic [127:0]         vtx_mem_addr,
  output logic [127:0]         vtx_mem_wdata,
  output logic [127:0]         vtx_mem_rdata,
  output logic [15:0]          vtx_mem_ben,
  output logic [511:0]         vtx_cprs_pre,
  output logic [511:0]         vtx_cprs_post,
  output logic [31:0]          vtx_rand_sample,
  output logic                 vtx_overflow,
  output logic                 vtx_proto_err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SNAP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] req_ptr, ack_ptr;
  logic       issue_fire, rsp_fire, req_fire, ack_fire;

  assign issue_fire = bus.cop_insn_valid & bus.cop_insn_ready;
  assign rsp_fire   = bus.cop_rsp_valid & bus.cop_rsp_ready;
  assign req_fire   = bus.mem_req & bus.mem_gnt;
  assign ack_fire   = bus.mem_ack;
  assign dbg_state  = state;

  // State register.
  always_ff @(posedge vtx_clk or posedge vtx_reset) begin
    if (vtx_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state: IDLE -> BUSY on issue, BUSY -> SNAP on result, SNAP lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_fire) state_nxt = BUSY;
      BUSY:    if (rsp_fire)   state_nxt = SNAP;
      SNAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture datapath: latches, memory slots, pointers and sticky flags.
  always_ff @(posedge vtx_clk or posedge vtx_reset) begin
    if (vtx_reset) begin
      req_ptr          <= 3'd0;
      ack_ptr          <= 3'd0;
      vtx_valid        <= 1'b0;
      vtx_instr_enc    <= 32'd0;
      vtx_instr_rs1    <= 32'd0;
      vtx_instr_result <= 3'd0;
      vtx_instr_wdata  <= 32'd0;
      vtx_instr_waddr  <= 5'd0;
      vtx_instr_wen    <= 1'b0;
      vtx_mem_cen      <= 4'd0;
      vtx_mem_wen      <= 4'd0;
      vtx_mem_error    <= 4'd0;
      vtx_mem_addr     <= 128'd0;
      vtx_mem_wdata    <= 128'd0;
      vtx_mem_rdata    <= 128'd0;
      vtx_mem_ben      <= 16'd0;
      vtx_cprs_pre     <= 512'd0;
      vtx_cprs_post    <= 512'd0;
      vtx_overflow     <= 1'b0;
      vtx_proto_err    <= 1'b0;
    end else begin
      vtx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_fire) begin
            vtx_instr_enc <= bus.cop_insn_enc;
            vtx_instr_rs1 <= bus.cop_insn_rs1;
            vtx_cprs_pre  <= cprs_in;
            vtx_mem_cen   <= 4'd0;
            vtx_mem_wen   <= 4'd0;
            vtx_mem_error <= 4'd0;
            vtx_mem_addr  <= 128'd0;
            vtx_mem_wdata <= 128'd0;
            vtx_mem_rdata <= 128'd0;
            vtx_mem_ben   <= 16'd0;
            req_ptr       <= 3'd0;
            ack_ptr       <= 3'd0;
          end
          // A result or memory response with no instruction in flight is a protocol slip.
          if (rsp_fire || ack_fire) vtx_proto_err <= 1'b1;
        end
        BUSY: begin
          if (issue_fire) vtx_proto_err <= 1'b1;
          if (req_fire) begin
            if (req_ptr == 3'd4) begin
              vtx_overflow <= 1'b1;
            end else begin
              vtx_mem_cen[req_ptr[1:0]]                 <= 1'b1;
              vtx_mem_wen[req_ptr[1:0]]                 <= bus.mem_wen;
              vtx_mem_addr[{req_ptr[1:0], 5'd0} +: 32]  <= bus.mem_addr;
              vtx_mem_wdata[{req_ptr[1:0], 5'd0} +: 32] <= bus.mem_wdata;
              vtx_mem_ben[{req_ptr[1:0], 2'd0} +: 4]    <= bus.mem_ben;
              req_ptr                                   <= req_ptr + 3'd1;
            end
          end
          if (ack_fire) begin
            if (ack_ptr == 3'd4) begin
              vtx_overflow <= 1'b1;
            end else begin
              vtx_mem_rdata[{ack_ptr[1:0], 5'd0} +: 32] <= bus.mem_rdata;
              vtx_mem_error[ack_ptr[1:0]]               <= bus.mem_error;
              ack_ptr                                   <= ack_ptr + 3'd1;
            end
          end
          if (rsp_fire) begin
            vtx_instr_result <= bus.cop_rsp_result;
            vtx_instr_wdata  <= bus.cop_rsp_wdata;
            vtx_instr_waddr  <= bus.cop_rsp_waddr;
            vtx_instr_wen    <= bus.cop_rsp_wen;
          end
        end
        SNAP: begin
          if (issue_fire) vtx_proto_err <= 1'b1;
          vtx_cprs_post <= cprs_in;
          vtx_valid     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef VTX_RAND_SAMPLE_EN
  // TRNG sample taken at the moment the instruction is accepted.
  always_ff @(posedge vtx_clk or posedge vtx_reset) begin
    if (vtx_reset)                       vtx_rand_sample <= 32'd0;
    else if (state == IDLE && issue_fire) vtx_rand_sample <= rand_in;
  end
`else
  logic unused_rand;
  assign unused_rand     = ^rand_in;
  assign vtx_rand_sample = 32'd0;
`endif

endmodule

// File: tb/tb_vtx_trace_capture.sv
// Directed self-checking bench for vtx_trace_capture.
module tb_vtx_trace_capture;
  logic         vtx_clk;
  logic         vtx_reset;
  logic [511:0] cprs_in;
  logic [31:0]  rand_in;
  logic         vtx_valid;
  logic [31:0]  vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata;
  logic [2:0]   vtx_instr_result;
  logic [4:0]   vtx_instr_waddr;
  logic         vtx_instr_wen;
  logic [3:0]   vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
  logic [127:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
  logic [15:0]  vtx_mem_ben;
  logic [511:0] vtx_cprs_pre, vtx_cprs_post;
  logic [31:0]  vtx_rand_sample;
  logic         vtx_overflow, vtx_proto_err;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  vtx_trace_capture_if bus ();

  vtx_trace_capture dut (
    .vtx_clk(vtx_clk), .vtx_reset(vtx_reset), .bus(bus),
    .cprs_in(cprs_in), .rand_in(rand_in),
    .vtx_valid(vtx_valid),
    .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1),
    .vtx_instr_result(vtx_instr_result), .vtx_instr_wdata(vtx_instr_wdata),
    .vtx_instr_waddr(vtx_instr_waddr), .vtx_instr_wen(vtx_instr_wen),
    .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen), .vtx_mem_error(vtx_mem_error),
    .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata),
    .vtx_mem_rdata(vtx_mem_rdata), .vtx_mem_ben(vtx_mem_ben),
    .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post),
    .vtx_rand_sample(vtx_rand_sample),
    .vtx_overflow(vtx_overflow), .vtx_proto_err(vtx_proto_err),
    .dbg_state(dbg_state)
  );

  // Clock / reset block.
  initial vtx_clk = 1'b0;
  always #5 vtx_clk = ~vtx_clk;

  // Driver tasks.
  task automatic clear_strobes();
    bus.cop_insn_valid = 1'b0; bus.cop_insn_ready = 1'b0;
    bus.cop_rsp_valid  = 1'b0; bus.cop_rsp_ready  = 1'b0;
    bus.mem_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge vtx_clk);
    #1;
    clear_strobes();
  endtask

  task automatic set_issue(input logic [31:0] enc, input logic [31:0] rs1);
    bus.cop_insn_valid = 1'b1; bus.cop_insn_ready = 1'b1;
    bus.cop_insn_enc = enc; bus.cop_insn_rs1 = rs1;
  endtask

  task automatic set_rsp(input logic [2:0] res, input logic [31:0] wd,
                         input logic [4:0] wa, input logic we);
    bus.cop_rsp_valid = 1'b1; bus.cop_rsp_ready = 1'b1;
    bus.cop_rsp_result = res; bus.cop_rsp_wdata = wd;
    bus.cop_rsp_waddr = wa; bus.cop_rsp_wen = we;
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ben);
    bus.mem_req = 1'b1; bus.mem_gnt = 1'b1;
    bus.mem_wen = we; bus.mem_addr = addr; bus.mem_wdata = wd; bus.mem_ben = ben;
  endtask

  task automatic set_ack(input logic [31:0] rd, input logic err);
    bus.mem_ack = 1'b1; bus.mem_rdata = rd; bus.mem_error = err;
  endtask

  task automatic do_reset();
    vtx_reset = 1'b1;
    tick();
    vtx_reset = 1'b0;
  endtask

  task automatic test_reset();
    vtx_reset = 1'b1;
    tick(); tick();
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
    n_checks++; if (vtx_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", vtx_valid); else n_pass++;
    n_checks++; if (vtx_mem_cen !== 4'd0) $display("FAIL reset_cen: got %b want 0000", vtx_mem_cen); else n_pass++;
    n_checks++; if ({vtx_overflow, vtx_proto_err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {vtx_overflow, vtx_proto_err}); else n_pass++;
    n_checks++; if (vtx_instr_enc !== 32'd0) $display("FAIL reset_enc: got %h want 0", vtx_instr_enc); else n_pass++;
    n_checks++; if (vtx_rand_sample !== 32'd0) $display("FAIL reset_rand: got %h want 0", vtx_rand_sample); else n_pass++;
    vtx_reset = 1'b0;
    tick();
  endtask

  task automatic test_no_mem();
    // valid without ready must not start a capture
    bus.cop_insn_valid = 1'b1; bus.cop_insn_enc = 32'hFFFF_0000;
    tick();
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL nomem_noready: got %0d want 0", dbg_state); else n_pass++;
    set_issue(32'h0000_102B, 32'h1234_5678);
    tick();
    n_checks++; if (dbg_state !== 2'd1) $display("FAIL nomem_busy: got %0d want 1", dbg_state); else n_pass++;
    tick();
    set_rsp(3'd0, 32'd0, 5'd0, 1'b0);
    tick();
    n_checks++; if ({dbg_state, vtx_valid} !== 3'b100) $display("FAIL nomem_snap: got %b want 100", {dbg_state, vtx_valid}); else n_pass++;
    tick();
    n_checks++; if (vtx_valid !== 1'b1) $display("FAIL nomem_valid: got %0b want 1", vtx_valid); else n_pass++;
    n_checks++; if (vtx_mem_cen !== 4'b0000) $display("FAIL nomem_cen: got %b want 0000", vtx_mem_cen); else n_pass++;
    n_checks++; if (vtx_instr_enc !== 32'h0000_102B) $display("FAIL nomem_enc: got %h want 0000102b", vtx_instr_enc); else n_pass++;
    n_checks++; if (vtx_instr_rs1 !== 32'h1234_5678) $display("FAIL nomem_rs1: got %h want 12345678", vtx_instr_rs1); else n_pass++;
    tick();
    n_checks++; if (vtx_valid !== 1'b0) $display("FAIL nomem_pulse: got %0b want 0", vtx_valid); else n_pass++;
  endtask

  task automatic test_two_loads();
    set_issue(32'h0000_2003, 32'h0);
    tick();
    set_req(1'b0, 32'h100, 32'h0, 4'hF);
    tick();
    set_req(1'b0, 32'h104, 32'h0, 4'hF);
    set_ack(32'hAAAA_AAAA, 1'b0);
    tick();
    set_ack(32'h5555_5555, 1'b1);
    tick();
    set_rsp(3'd5, 32'hDEAD_BEEF, 5'd7, 1'b1);
    tick(); tick();
    n_checks++; if (vtx_valid !== 1'b1) $display("FAIL loads_valid: got %0b want 1", vtx_valid); else n_pass++;
    n_checks++; if (vtx_mem_cen !== 4'b0011) $display("FAIL loads_cen: got %b want 0011", vtx_mem_cen); else n_pass++;
    n_checks++; if (vtx_mem_rdata[31:0] !== 32'hAAAA_AAAA) $display("FAIL loads_rdata0: got %h want aaaaaaaa", vtx_mem_rdata[31:0]); else n_pass++;
    n_checks++; if (vtx_mem_rdata[63:32] !== 32'h5555_5555) $display("FAIL loads_rdata1: got %h want 55555555", vtx_mem_rdata[63:32]); else n_pass++;
    n_checks++; if (vtx_mem_addr[63:0] !== 64'h0000_0104_0000_0100) $display("FAIL loads_addr: got %h want 0000010400000100", vtx_mem_addr[63:0]); else n_pass++;
    n_checks++; if (vtx_mem_error !== 4'b0010) $display("FAIL loads_error: got %b want 0010", vtx_mem_error); else n_pass++;
    n_checks++; if (vtx_mem_ben !== 16'h00FF) $display("FAIL loads_ben: got %h want 00ff", vtx_mem_ben); else n_pass++;
    n_checks++; if ({vtx_instr_result, vtx_instr_waddr, vtx_instr_wen} !== {3'd5, 5'd7, 1'b1}) $display("FAIL loads_rsp: got %h want %h", {vtx_instr_result, vtx_instr_waddr, vtx_instr_wen}, {3'd5, 5'd7, 1'b1}); else n_pass++;
    n_checks++; if (vtx_instr_wdata !== 32'hDEAD_BEEF) $display("FAIL loads_wdata: got %h want deadbeef", vtx_instr_wdata); else n_pass++;
    n_checks++; if (vtx_overflow !== 1'b0) $display("FAIL loads_ovf: got %0b want 0", vtx_overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    set_issue(32'h0000_3003, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 32'h10 * (i + 1), 32'hD0 + i, 4'hC);
      tick();
    end
    // fifth request, an ack and the result all land in the same cycle
    set_req(1'b1, 32'h50, 32'hD4, 4'hC);
    set_ack(32'h77, 1'b0);
    set_rsp(3'd1, 32'h0, 5'd0, 1'b0);
    tick();
    n_checks++; if ({dbg_state, vtx_overflow} !== 3'b101) $display("FAIL ovf_flag: got %b want 101", {dbg_state, vtx_overflow}); else n_pass++;
    tick();
    n_checks++; if (vtx_mem_cen !== 4'b1111) $display("FAIL ovf_cen: got %b want 1111", vtx_mem_cen); else n_pass++;
    n_checks++; if (vtx_mem_wen !== 4'b1111) $display("FAIL ovf_wen: got %b want 1111", vtx_mem_wen); else n_pass++;
    n_checks++; if (vtx_mem_addr !== 128'h0000_0040_0000_0030_0000_0020_0000_0010) $display("FAIL ovf_addr: got %h want 00000040000000300000002000000010", vtx_mem_addr); else n_pass++;
    n_checks++; if (vtx_mem_wdata[127:96] !== 32'hD3) $display("FAIL ovf_wdata3: got %h want 000000d3", vtx_mem_wdata[127:96]); else n_pass++;
    n_checks++; if (vtx_mem_rdata[31:0] !== 32'h77) $display("FAIL ovf_rdata0: got %h want 00000077", vtx_mem_rdata[31:0]); else n_pass++;
    n_checks++; if (vtx_mem_ben !== 16'hCCCC) $display("FAIL ovf_ben: got %h want cccc", vtx_mem_ben); else n_pass++;
  endtask

  task automatic test_cprs();
    cprs_in = 512'd0;
    cprs_in[127:96] = 32'h1;
    rand_in = 32'hCAFE_0001;
    set_issue(32'h0000_4003, 32'h0);
    tick();
    n_checks++; if (vtx_mem_cen !== 4'b0000) $display("FAIL cprs_slots_clear: got %b want 0000", vtx_mem_cen); else n_pass++;
    cprs_in[127:96] = 32'h5;
    set_rsp(3'd0, 32'h0, 5'd0, 1'b0);
    tick();
    cprs_in[127:96] = 32'h2;
    tick();
    n_checks++; if (vtx_valid !== 1'b1) $display("FAIL cprs_valid: got %0b want 1", vtx_valid); else n_pass++;
    n_checks++; if (vtx_cprs_pre[127:96] !== 32'h1) $display("FAIL cprs_pre: got %h want 00000001", vtx_cprs_pre[127:96]); else n_pass++;
    n_checks++; if (vtx_cprs_post[127:96] !== 32'h2) $display("FAIL cprs_post: got %h want 00000002", vtx_cprs_post[127:96]); else n_pass++;
    n_checks++; if (vtx_rand_sample !== 32'd0) $display("FAIL cprs_rand_off: got %h want 0", vtx_rand_sample); else n_pass++;
    n_checks++; if (vtx_proto_err !== 1'b0) $display("FAIL cprs_perr: got %0b want 0", vtx_proto_err); else n_pass++;
  endtask

  task automatic test_proto_issue();
    set_issue(32'h0000_00A1, 32'h11);
    tick();
    set_issue(32'h0000_00B2, 32'h22);
    tick();
    n_checks++; if ({dbg_state, vtx_proto_err} !== 3'b011) $display("FAIL pissue_flag: got %b want 011", {dbg_state, vtx_proto_err}); else n_pass++;
    set_rsp(3'd2, 32'h0, 5'd0, 1'b0);
    tick(); tick();
    n_checks++; if (vtx_valid !== 1'b1) $display("FAIL pissue_valid: got %0b want 1", vtx_valid); else n_pass++;
    n_checks++; if ({vtx_instr_enc, vtx_instr_rs1} !== {32'hA1, 32'h11}) $display("FAIL pissue_fields: got %h want %h", {vtx_instr_enc, vtx_instr_rs1}, {32'hA1, 32'h11}); else n_pass++;
  endtask

  task automatic test_rsp_idle();
    do_reset();
    n_checks++; if (vtx_proto_err !== 1'b0) $display("FAIL prsp_cleared: got %0b want 0", vtx_proto_err); else n_pass++;
    set_rsp(3'd3, 32'h9, 5'd1, 1'b1);
    tick();
    n_checks++; if ({dbg_state, vtx_proto_err} !== 3'b001) $display("FAIL prsp_flag: got %b want 001", {dbg_state, vtx_proto_err}); else n_pass++;
    tick();
    n_checks++; if ({vtx_valid, vtx_instr_result} !== 4'd0) $display("FAIL prsp_ignored: got %h want 0", {vtx_valid, vtx_instr_result}); else n_pass++;
  endtask

  task automatic test_idle_mem();
    do_reset();
    set_req(1'b0, 32'h300, 32'h0, 4'hF);
    tick();
    n_checks++; if ({vtx_proto_err, vtx_mem_cen} !== 5'd0) $display("FAIL idle_req: got %b want 00000", {vtx_proto_err, vtx_mem_cen}); else n_pass++;
    set_ack(32'h1234, 1'b0);
    tick();
    n_checks++; if (vtx_proto_err !== 1'b1) $display("FAIL idle_ack: got %0b want 1", vtx_proto_err); else n_pass++;
    n_checks++; if (vtx_mem_rdata[31:0] !== 32'd0) $display("FAIL idle_ack_ignored: got %h want 0", vtx_mem_rdata[31:0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cprs_in = {16{32'h0F0F_0F0F}};
    set_issue(32'h0000_0011, 32'h0);
    tick();
    set_rsp(3'd0, 32'h0, 5'd0, 1'b0);
    tick(); tick();
    n_checks++; if ({vtx_valid, dbg_state} !== 3'b100) $display("FAIL b2b_valid: got %b want 100", {vtx_valid, dbg_state}); else n_pass++;
    set_issue(32'h0000_0022, 32'h0);
    tick();
    n_checks++; if ({dbg_state, vtx_proto_err, vtx_valid} !== 4'b0100) $display("FAIL b2b_accept: got %b want 0100", {dbg_state, vtx_proto_err, vtx_valid}); else n_pass++;
    n_checks++; if (vtx_instr_enc !== 32'h22) $display("FAIL b2b_enc: got %h want 00000022", vtx_instr_enc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_req(1'b0, 32'h400, 32'h0, 4'hF);
    tick();
    n_checks++; if (vtx_mem_cen !== 4'b0001) $display("FAIL rmid_slot: got %b want 0001", vtx_mem_cen); else n_pass++;
    vtx_reset = 1'b1;
    #1;
    n_checks++; if ({dbg_state, vtx_mem_cen} !== 6'd0) $display("FAIL rmid_async: got %b want 000000", {dbg_state, vtx_mem_cen}); else n_pass++;
    n_checks++; if ({vtx_instr_enc, vtx_cprs_pre[31:0], vtx_cprs_post[31:0]} !== 96'd0) $display("FAIL rmid_latches: got %h want 0", {vtx_instr_enc, vtx_cprs_pre[31:0], vtx_cprs_post[31:0]}); else n_pass++;
    @(posedge vtx_clk); #1;
    vtx_reset = 1'b0;
    set_rsp(3'd4, 32'h5, 5'd3, 1'b1);
    tick();
    n_checks++; if ({dbg_state, vtx_valid, vtx_proto_err} !== 4'b0001) $display("FAIL rmid_rsp: got %b want 0001", {dbg_state, vtx_valid, vtx_proto_err}); else n_pass++;
    tick();
    n_checks++; if ({vtx_valid, vtx_instr_result, vtx_instr_wdata, vtx_mem_addr} !== 164'd0) $display("FAIL rmid_outputs: got %h want 0", {vtx_valid, vtx_instr_result, vtx_instr_wdata, vtx_mem_addr}); else n_pass++;
    n_checks++; if (vtx_overflow !== 1'b0) $display("FAIL rmid_ovf: got %0b want 0", vtx_overflow); else n_pass++;
  endtask

  initial begin
    vtx_reset = 1'b1;
    cprs_in = 512'd0;
    rand_in = 32'd0;
    bus.cop_insn_enc = 32'd0; bus.cop_insn_rs1 = 32'd0;
    bus.cop_rsp_result = 3'd0; bus.cop_rsp_wdata = 32'd0;
    bus.cop_rsp_waddr = 5'd0; bus.cop_rsp_wen = 1'b0;
    bus.mem_wen = 1'b0; bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
    bus.mem_ben = 4'd0; bus.mem_rdata = 32'd0; bus.mem_error = 1'b0;
    clear_strobes();
    test_reset();
    test_no_mem();
    test_two_loads();
    test_overflow();
    test_cprs();
    test_proto_issue();
    test_rsp_idle();
    test_idle_mem();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
